// File: rtl/udp_user_pkt_gen_pkg.sv
// Shared types and helpers for the UDP user-stream test-traffic generator.
package udp_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

  localparam logic [15:0] MAGIC_DEFAULT = 16'hA55A;
  localparam int unsigned BEAT_BYTES    = 8;

  // MSB-aligned keep for the final beat; rem == 0 means the beat is full.
  function automatic logic [7:0] keep_from_rem(input logic [2:0] rem);
    logic [7:0] k;
    k = '0;
    for (int unsigned i = 0; i < BEAT_BYTES; i++) begin
      k[7-i] = (rem == 3'd0) || (i < 32'(rem));
    end
    return k;
  endfunction

endpackage

// File: rtl/udp_user_pkt_gen.sv
// Generates runs of UDP payloads carrying {seq, magic/len | beat index} so a
// receive-side checker can validate ordering and length of every packet.
module udp_user_pkt_gen
  import udp_gen_pkg::*;
#(
  parameter logic [15:0] P_MAGIC   = MAGIC_DEFAULT,
  parameter logic [15:0] P_MAX_LEN = 16'd8192
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] i_pkt_len,
  input  logic [31:0] i_pkt_num,
  input  logic [15:0] i_gap_cycles,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_pkt_cnt,
  output logic [63:0] m_axis_user_data,
  output logic [31:0] m_axis_user_user,
  output logic [7:0]  m_axis_user_keep,
  output logic        m_axis_user_last,
  output logic        m_axis_user_valid,
  input  logic        m_axis_user_ready
);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] num_q, num_d;
  logic [15:0] gap_q, gap_d;
  logic [12:0] nbeats_q, nbeats_d;
  logic [12:0] beat_q, beat_d;
  logic [15:0] gcnt_q, gcnt_d;
  // Completed-packet count doubles as the sequence number of the packet in flight.
  logic [31:0] cnt_q, cnt_d;
  logic        stop_q, stop_d;
  logic        done_q, done_d;

  logic        start_ok, is_last, hs, stop_pend, run_end;
  logic [7:0]  keep_w;
  logic [63:0] raw_w;

  assign start_ok  = i_start && (i_pkt_len != 16'd0) && (i_pkt_len <= P_MAX_LEN);
  assign is_last   = (beat_q == nbeats_q - 13'd1);
  assign hs        = (state_q == ST_SEND) && m_axis_user_ready;
  assign stop_pend = stop_q | i_stop;
  assign run_end   = stop_pend || ((num_q != 32'd0) && (cnt_q + 32'd1 == num_q));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      num_q    <= '0;
      gap_q    <= '0;
      nbeats_q <= '0;
      beat_q   <= '0;
      gcnt_q   <= '0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      num_q    <= num_d;
      gap_q    <= gap_d;
      nbeats_q <= nbeats_d;
      beat_q   <= beat_d;
      gcnt_q   <= gcnt_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    num_d    = num_q;
    gap_d    = gap_q;
    nbeats_d = nbeats_q;
    beat_d   = beat_q;
    gcnt_d   = gcnt_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          len_d    = i_pkt_len;
          num_d    = i_pkt_num;
          gap_d    = i_gap_cycles;
          // ceil(len/8) without a wide adder: whole beats plus one for any tail
          nbeats_d = i_pkt_len[15:3] + {12'd0, |i_pkt_len[2:0]};
          beat_d   = '0;
          cnt_d    = '0;
          stop_d   = 1'b0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_stop) stop_d = 1'b1;
        if (hs) begin
          if (is_last) begin
            cnt_d  = cnt_q + 32'd1;
            beat_d = '0;
            if (run_end) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              stop_d  = 1'b0;
            end else if (gap_q != 16'd0) begin
              state_d = ST_GAP;
              gcnt_d  = gap_q - 16'd1;
            end
          end else begin
            beat_d = beat_q + 13'd1;
          end
        end
      end
      ST_GAP: begin
        if (stop_pend) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          stop_d  = 1'b0;
        end else if (gcnt_q == 16'd0) begin
          state_d = ST_SEND;
        end else begin
          gcnt_d = gcnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    keep_w = '0;
    if (state_q == ST_SEND) keep_w = is_last ? keep_from_rem(len_q[2:0]) : 8'hFF;
    raw_w = (beat_q == 13'd0) ? {cnt_q, P_MAGIC, len_q} : {cnt_q, 19'd0, beat_q};
    m_axis_user_data = '0;
    for (int unsigned i = 0; i < BEAT_BYTES; i++) begin
      if (keep_w[i]) m_axis_user_data[i*8 +: 8] = raw_w[i*8 +: 8];
    end
  end

  assign m_axis_user_keep  = keep_w;
  assign m_axis_user_valid = (state_q == ST_SEND);
  assign m_axis_user_last  = (state_q == ST_SEND) && is_last;
  assign m_axis_user_user  = (state_q == ST_SEND) ? {len_q, 16'h0000} : '0;
  assign o_busy            = (state_q != ST_IDLE);
  assign o_done            = done_q;
  assign o_pkt_cnt         = cnt_q;

endmodule

// File: doc/udp_user_pkt_gen.md
Name: udp_user_pkt_gen

Overview:
- Test-traffic transmitter that drives the UDP stack's user TX stream (`s_axis_user_*` on the stack side).
- Generates a configured number of UDP payloads with a self-describing, checkable pattern, honouring `ready` backpressure.
- Sits between board control logic (VIO/registers) and the stack's user port.
- Its pattern is what a future receive-side checker on `m_axis_user_*` validates.

Parameters:
- P_MAGIC, 16'hA55A, marker placed in the first beat of every packet.
- P_MAX_LEN, 16'd8192, largest accepted payload length in bytes; start is ignored above this.

Ports:
- i_clk  in  1  XGMII-domain clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse; latches config and begins a run
- i_stop  in  1  one-cycle pulse; ends the run after the current packet
- i_pkt_len  in  16  payload bytes per packet; valid range 1..P_MAX_LEN
- i_pkt_num  in  32  packets per run; 0 = continuous until stop
- i_gap_cycles  in  16  idle cycles inserted between packets
- o_busy  out  1  high while not IDLE
- o_done  out  1  one-cycle pulse when a run ends
- o_pkt_cnt  out  32  packets completed in the current or last run
- m_axis_user_data  out  64  payload; byte 0 on [63:56]
- m_axis_user_user  out  32  {len[15:0], 16'h0000}, constant for the whole packet
- m_axis_user_keep  out  8  keep[7] = byte 0; MSB-aligned
- m_axis_user_last  out  1  last beat of packet
- m_axis_user_valid  out  1  beat valid
- m_axis_user_ready  in  1  sink ready

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-packet drops the packet immediately; no completion is required.
- States and transitions:
  - IDLE: on i_start with 1 <= i_pkt_len <= P_MAX_LEN:
    - latch len, num, gap;
    - clear o_pkt_cnt and seq;
    - go to SEND.
  - IDLE, invalid start: i_start with i_pkt_len = 0 or above P_MAX_LEN is ignored (stay IDLE).
  - SEND: valid=1. The beat index advances only on valid & ready. On the last-beat handshake:
    - o_pkt_cnt++ and seq++;
    - if stop is pending, or num != 0 and o_pkt_cnt+1 == num, go to IDLE and pulse o_done;
    - else if gap != 0, go to GAP;
    - else stay in SEND with beat index 0 (back-to-back, no bubble).
  - GAP: valid=0; count gap cycles, then SEND. A stop pending here goes to IDLE with o_done.
- Latency: i_start at cycle t gives valid=1 at cycle t+1.
- Beat count: beats = ceil(len/8), computed as (len+7)>>3, 13 bits.
- Last-beat keep: rem = len[2:0]; rem == 0 gives 8'hFF, otherwise 8'hFF << (8-rem).
- Payload:
  - Beat 0: {seq[31:0], P_MAGIC, len}.
  - Beat k>0: {seq[31:0], 19'd0, k[12:0]}.
  - Bytes outside keep are driven 0.
- AXI rules:
  - Once valid is high, data/user/keep/last hold until ready.
  - valid is never dropped mid-packet.
  - ready is ignored when valid is low.
- i_stop:
  - Registered as stop_pending.
  - Never truncates a packet.
  - Ignored in IDLE.
  - Cleared on entry to IDLE.
- i_start while busy is ignored.
- Simultaneous start and stop in IDLE: start wins, stop is ignored.
- Counter width: o_pkt_cnt and seq wrap at 2^32 in continuous mode without error.
- Single-beat packets (len <= 8): last=1 on beat 0, keep per the rem rule.
- o_pkt_cnt holds its value after done until the next accepted start.

Decomposition:
- Package udp_gen_pkg:
  - state encoding (IDLE/SEND/GAP);
  - P_MAGIC default;
  - beat-width constant 8;
  - keep-from-remainder function.
- Single module; no sub-module needed. Beat counter, gap counter and FSM fit in about 200 lines.

Test Plan:
- len=20, num=1, gap=0, ready=1:
  - 3 beats; beat0 = 0x00000000_A55A_0014;
  - last keep 8'hF0; user 0x00140000;
  - o_done one cycle after beat 2; o_pkt_cnt=1.
- len=16, num=3, gap=0, ready=1:
  - 6 contiguous valid beats, no bubble;
  - seq 0,1,2 in beat0 upper words; o_pkt_cnt=3.
- len=64, num=2, ready random 50%:
  - data/keep/last stable whenever valid & !ready;
  - 8 beats each; exactly 2 last handshakes.
- len=24, num=2, gap=5:
  - valid low for exactly 5 cycles between the last of packet 0 and beat0 of packet 1.
- num=0, len=40, i_stop pulsed on beat 2 of packet 4:
  - packet 4 completes all 5 beats, then IDLE;
  - o_done pulse; o_pkt_cnt=5.
- Corner cases:
  - i_start with len=0: no valid, o_busy stays 0.
  - Reset asserted mid-packet: valid=0 immediately (async), then a fresh start restarts seq at 0.
